// File: rtl/counter_sequencer_pkg.sv
// Shared types and constants for the counter sequencer and its datapath.
// The state enum is also exported on the interface so checkers can observe it.
package counter_sequencer_pkg;

  localparam int WIDTH_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/counter_sequencer_if.sv
// Control and status bundle of the counter sequencer; the FSM state is exported for observation.
// Start is a level request sampled only in IDLE: there is no ready, a request raised in RUN/DONE is dropped, never queued.
interface counter_sequencer_if
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             Start;
  logic [WIDTH-1:0] Limit;
  logic             Dir;
  logic             Hold;
  logic             Abort;
  logic [WIDTH-1:0] Q;
  logic             Busy;
  logic             Done;
  state_t           State;

  modport master (
    output Start,
    output Limit,
    output Dir,
    output Hold,
    output Abort,
    input  Q,
    input  Busy,
    input  Done,
    input  State
  );

  modport slave (
    input  Start,
    input  Limit,
    input  Dir,
    input  Hold,
    input  Abort,
    output Q,
    output Busy,
    output Done,
    output State
  );

endinterface

// File: rtl/updown_counter.sv
// Loadable up/down counter: Load has priority over En; wraps modulo 2^WIDTH,
// although the sequencer never lets it step past its end value.
module updown_counter
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             nRst,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             En,
  input  logic             Up,
  output logic [WIDTH-1:0] Q
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      Q <= '0;
    end else if (Load) begin
      Q <= LoadVal;
    end else if (En) begin
      if (Up) begin
        Q <= Q + ONE;
      end else begin
        Q <= Q - ONE;
      end
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Run sequencer: accepts a run in IDLE, counts toward the captured end value in RUN,
// then pulses Done for one cycle. Busy/Done are pure decodes of the state register.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                Clk,
  input  logic                nRst,
  counter_sequencer_if.slave  bus
);

  state_t           state_r;
  state_t           state_nxt;
  logic [WIDTH-1:0] lim_r;
  logic             dir_r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] end_val;
  logic             at_end;
  logic             accept;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_val;
  logic             cnt_en;

  assign end_val = dir_r ? lim_r : '0;
  assign at_end  = (q == end_val);
  assign accept  = (state_r == IDLE) && bus.Start;

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Limit/Dir are captured only on acceptance so changes during a run are invisible.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      lim_r <= '0;
      dir_r <= 1'b1;
    end else if (accept) begin
      lim_r <= bus.Limit;
      dir_r <= bus.Dir;
    end
  end

  always_comb begin
    state_nxt    = state_r;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.Start) begin
          cnt_load     = 1'b1;
          cnt_load_val = bus.Dir ? '0 : bus.Limit;
          state_nxt    = RUN;
        end
      end
      RUN: begin
        // Abort beats completion, completion beats Hold.
        if (bus.Abort) begin
          cnt_load     = 1'b1;
          cnt_load_val = '0;
          state_nxt    = IDLE;
        end else if (at_end) begin
          state_nxt = DONE;
        end else if (!bus.Hold) begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  updown_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .Clk     (Clk),
    .nRst    (nRst),
    .Load    (cnt_load),
    .LoadVal (cnt_load_val),
    .En      (cnt_en),
    .Up      (dir_r),
    .Q       (q)
  );

  assign bus.Q     = q;
  assign bus.Busy  = (state_r == RUN);
  assign bus.Done  = (state_r == DONE);
  assign bus.State = state_r;

endmodule
